// File: rtl/logic_ops.sv
// logic_ops: registered bitwise logic unit (NOT / AND / OR / optional XOR).
// One request per cycle, one cycle of latency, no backpressure.
// The result, zero flag and illegal flag hold their values while no request
// arrives.
// Configuration macro: LOGIC_OPS_XOR_EN
//   When defined, op 2'b11 computes a XOR b.
//   When undefined, op 2'b11 is reported as illegal and returns zero.
module logic_ops #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic             out_valid,
  output logic             illegal
);

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // The zero flag looks at every bit of the result, so it is never fooled by
  // a partially cleared word.
  function automatic logic all_zero(input logic [WIDTH-1:0] value);
    all_zero = (value == {WIDTH{1'b0}});
  endfunction

  logic [WIDTH-1:0] result_s;
  logic             illegal_s;
  logic [WIDTH-1:0] c_r;
  logic             zero_r;
  logic             out_valid_r;
  logic             illegal_r;

  // Decode the operation and form the bitwise result for the current request.
  always_comb begin
    result_s  = {WIDTH{1'b0}};
    illegal_s = 1'b0;
    case (op)
      OP_NOT: begin
        result_s  = ~a;
        illegal_s = 1'b0;
      end
      OP_AND: begin
        result_s  = a & b;
        illegal_s = 1'b0;
      end
      OP_OR: begin
        result_s  = a | b;
        illegal_s = 1'b0;
      end
      OP_XOR: begin
`ifdef LOGIC_OPS_XOR_EN
        result_s  = a ^ b;
        illegal_s = 1'b0;
`else
        result_s  = {WIDTH{1'b0}};
        illegal_s = 1'b1;
`endif
      end
      default: begin
        result_s  = {WIDTH{1'b0}};
        illegal_s = 1'b1;
      end
    endcase
  end

  // Capture each accepted request.
  // Between requests, drop out_valid and hold the result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_r         <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else if (in_valid) begin
      c_r         <= result_s;
      zero_r      <= all_zero(result_s);
      out_valid_r <= 1'b1;
      illegal_r   <= illegal_s;
    end else begin
      c_r         <= c_r;
      zero_r      <= zero_r;
      out_valid_r <= 1'b0;
      illegal_r   <= illegal_r;
    end
  end

  assign c         = c_r;
  assign zero      = zero_r;
  assign out_valid = out_valid_r;
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_logic_ops.sv
// tb_logic_ops: directed self-checking bench for logic_ops (WIDTH = 20).
// Expectations for op 2'b11 follow the LOGIC_OPS_XOR_EN build setting.
module tb_logic_ops;

  localparam int W = 20;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         zero;
  logic         out_valid;
  logic         illegal;

  int total;
  int bad;

  logic_ops #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .op        (op),
    .a         (a),
    .b         (b),
    .c         (c),
    .zero      (zero),
    .out_valid (out_valid),
    .illegal   (illegal)
  );

  // Free-running clock, 10 time-unit period, first rising edge at t = 5.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp)
    else begin
      bad = bad + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] ec, input logic ez,
                         input logic eov, input logic eil);
    chk({tag, ".c"}, {44'd0, c}, {44'd0, ec});
    chk({tag, ".zero"}, {63'd0, zero}, {63'd0, ez});
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, eov});
    chk({tag, ".illegal"}, {63'd0, illegal}, {63'd0, eil});
  endtask

  // Drive a request on the falling edge, then step to 1 time unit after the
  // next rising edge, where the registered outputs are sampled.
  task automatic drive(input logic v, input logic [1:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb);
    @(negedge clk);
    in_valid = v;
    op       = o;
    a        = aa;
    b        = bb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    op       = 2'b00;
    a        = 20'h00000;
    b        = 20'h00000;

    // Reset is held across clock edges while a request is presented.
    #3;
    chk_all("reset_t3", 20'h00000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_all("reset_clocked", 20'h00000, 1'b0, 1'b0, 1'b0);

    // Release reset; the first request is accepted on the next rising edge.
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    drive(1'b1, 2'b00, 20'h00000, 20'h00000);
    chk_all("not_zero_in", 20'hFFFFF, 1'b0, 1'b1, 1'b0);

    drive(1'b1, 2'b00, 20'hFFFFF, 20'h12345);
    chk_all("not_ones_b_ignored", 20'h00000, 1'b1, 1'b1, 1'b0);

    // AND then OR on the same operands, back to back.
    drive(1'b1, 2'b01, 20'hF0F0F, 20'h0F0F0);
    chk_all("and_disjoint", 20'h00000, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 2'b10, 20'hF0F0F, 20'h0F0F0);
    chk_all("or_disjoint", 20'hFFFFF, 1'b0, 1'b1, 1'b0);

    drive(1'b1, 2'b01, 20'h12345, 20'h0F0F0);
    chk_all("and_mixed", 20'h02040, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 2'b10, 20'h12340, 20'h00005);
    chk_all("or_mixed", 20'h12345, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 2'b00, 20'h80001, 20'h00000);
    chk_all("not_edges", 20'h7FFFE, 1'b0, 1'b1, 1'b0);

    // Op 2'b11: XOR when enabled, otherwise illegal.
    drive(1'b1, 2'b11, 20'hFFFFF, 20'h0000F);
`ifdef LOGIC_OPS_XOR_EN
    chk_all("op11", 20'hFFFF0, 1'b0, 1'b1, 1'b0);
`else
    chk_all("op11", 20'h00000, 1'b1, 1'b1, 1'b1);
`endif

    // The illegal flag is recomputed by the next request.
    // The request is then followed by three idle cycles that hold the outputs.
    drive(1'b1, 2'b01, 20'hAAAAA, 20'hFFFFF);
    chk_all("and_hold_src", 20'hAAAAA, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 20'h00000, 20'h00000);
    chk_all("idle1", 20'hAAAAA, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b10, 20'hFFFFF, 20'hFFFFF);
    chk_all("idle2", 20'hAAAAA, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 2'b11, 20'h00000, 20'h00000);
    chk_all("idle3", 20'hAAAAA, 1'b0, 1'b0, 1'b0);

    // An illegal or zero result must also hold across an idle cycle.
    drive(1'b1, 2'b01, 20'h0000F, 20'h000F0);
    chk_all("zero_src", 20'h00000, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 20'h00000, 20'h00000);
    chk_all("zero_hold", 20'h00000, 1'b1, 1'b0, 1'b0);

    // Reset asserted mid-cycle with a request still being presented.
    drive(1'b1, 2'b10, 20'h55555, 20'h00000);
    chk_all("pre_reset", 20'h55555, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    op       = 2'b00;
    a        = 20'h0F0F0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("reset_async", 20'h00000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_all("reset_held", 20'h00000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_all("post_release_no_pulse", 20'h00000, 1'b0, 1'b0, 1'b0);

    // A fresh request after reset is accepted normally.
    drive(1'b1, 2'b00, 20'h0F0F0, 20'h00000);
    chk_all("post_reset_req", 20'hF0F0F, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 2'b00, 20'h00000, 20'h00000);
    chk_all("post_reset_idle", 20'hF0F0F, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
